// File: rtl/cnn_stream_pkg.sv
// Shared constants and FSM state encoding for the CNN frame streamer.
package cnn_stream_pkg;

    localparam int unsigned IMG_W_DEF = 28;
    localparam int unsigned IMG_H_DEF = 28;
    localparam int unsigned CLASS_W   = 4;
    localparam int unsigned PIX_W     = 8;

    localparam logic [PIX_W-1:0] FLUSH_PIX = 8'h00;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StCrst   = 3'd1;
    localparam state_t StSettle = 3'd2;
    localparam state_t StSend   = 3'd3;
    localparam state_t StFlush  = 3'd4;
    localparam state_t StWait   = 3'd5;
    localparam state_t StDone   = 3'd6;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_frame_streamer_if.sv
// Pixel RAM read port plus classifier stream/result signals, as seen by the streamer.
interface cnn_frame_streamer_if #(
    parameter int unsigned ADDR_W = 10
);
    import cnn_stream_pkg::*;

    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [PIX_W-1:0]    mem_rd_data;
    logic                cnn_rst_n;
    logic                cnn_in_valid;
    logic [PIX_W-1:0]    cnn_in_data;
    logic                cnn_class_valid;
    logic [CLASS_W-1:0]  cnn_class_out;

    modport master (
        output mem_rd_en, mem_addr, cnn_rst_n, cnn_in_valid, cnn_in_data,
        input  mem_rd_data, cnn_class_valid, cnn_class_out
    );

    modport slave (
        input  mem_rd_en, mem_addr, cnn_rst_n, cnn_in_valid, cnn_in_data,
        output mem_rd_data, cnn_class_valid, cnn_class_out
    );

endinterface

// File: rtl/stream_cnt.sv
// Loadable up-counter that stops at a terminal value and flags it.
module stream_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         term
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && !term) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == last);

endmodule

// File: rtl/cnn_frame_streamer.sv
// Drives one image from pixel RAM into the CNN classifier and reports the result.
// Define STATS_EN to enable the saturating frame/hit counters.
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int unsigned IMG_W       = IMG_W_DEF,
    parameter int unsigned IMG_H       = IMG_H_DEF,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned FLUSH_ROWS  = 15,
    parameter int unsigned RST_CYC     = 5,
    parameter int unsigned SETTLE_CYC  = 10,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CLASS_W-1:0]  label,
    output logic                busy,
    output logic                done,
    cnn_frame_streamer_if.master bus,
    output logic [CLASS_W-1:0]  res_class,
    output logic                res_hit,
    output logic                res_timeout,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         hit_cnt
);

    localparam int unsigned IMG_SIZE  = IMG_W * IMG_H;
    localparam int unsigned FLUSH_LEN = FLUSH_ROWS * IMG_W;
    localparam int unsigned PH_MAX    = max_u(max_u(IMG_SIZE, FLUSH_LEN),
                                              max_u(RST_CYC, SETTLE_CYC));
    localparam int unsigned PW        = $clog2(PH_MAX + 1);
    localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 1);

    state_t state_q, state_d;

    logic               active, accept, expire, stop;
    logic               phase_load, phase_term;
    logic [PW-1:0]      phase_cnt, phase_last;
    logic               tmo_load, tmo_term;
    logic [TW-1:0]      tmo_cnt;
    logic               unused_tmo;

    logic [CLASS_W-1:0] label_q, res_class_q;
    logic               res_hit_q, res_timeout_q;
    logic               cnn_rst_n_q, in_valid_q;
    logic [PIX_W-1:0]   in_data_q;

    assign active = (state_q == StSend) || (state_q == StFlush) || (state_q == StWait);
    assign accept = active && bus.cnn_class_valid;
    // A result arriving on the expiry cycle takes priority over the timeout.
    assign expire = active && tmo_term && !bus.cnn_class_valid;
    assign stop   = accept || expire;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start)      state_d = StCrst;
            StCrst:   if (phase_term) state_d = StSettle;
            StSettle: if (phase_term) state_d = StSend;
            StSend:   if (stop)       state_d = StDone;
                      else if (phase_term) state_d = StFlush;
            StFlush:  if (stop)       state_d = StDone;
                      else if (phase_term) state_d = StWait;
            StWait:   if (stop)       state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        phase_last = '0;
        unique case (state_q)
            StCrst:   phase_last = PW'(RST_CYC - 1);
            StSettle: phase_last = PW'(SETTLE_CYC - 1);
            StSend:   phase_last = PW'(IMG_SIZE - 1);
            StFlush:  phase_last = PW'(FLUSH_LEN - 1);
            default:  phase_last = '0;
        endcase
    end

    // Phase length counter restarts from zero on every state change.
    assign phase_load = (state_d != state_q);

    stream_cnt #(.W(PW)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (phase_load),
        .load_val ('0),
        .en       (1'b1),
        .last     (phase_last),
        .cnt      (phase_cnt),
        .term     (phase_term)
    );

    // Timeout window opens on the edge that enters SEND, one cycle before pixel 0 appears.
    assign tmo_load = (state_q == StSettle) && phase_term;

    stream_cnt #(.W(TW)) u_tmo_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmo_load),
        .load_val ('0),
        .en       (active),
        .last     (TW'(TIMEOUT_CYC)),
        .cnt      (tmo_cnt),
        .term     (tmo_term)
    );

    assign unused_tmo = ^tmo_cnt;

    // Address 0 is prefetched in the last SETTLE cycle, so SEND cycle k reads k+1.
    assign bus.mem_rd_en = ((state_q == StSettle) && phase_term) ||
                           ((state_q == StSend) && !phase_term);
    assign bus.mem_addr  = ((state_q == StSend) && !phase_term) ?
                           ADDR_W'(phase_cnt) + ADDR_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            label_q       <= '0;
            res_class_q   <= '0;
            res_hit_q     <= 1'b0;
            res_timeout_q <= 1'b0;
            cnn_rst_n_q   <= 1'b0;
            in_valid_q    <= 1'b0;
            in_data_q     <= '0;
        end else begin
            state_q <= state_d;

            if (state_d == StCrst) begin
                cnn_rst_n_q <= 1'b0;
            end else if (state_d == StSettle) begin
                cnn_rst_n_q <= 1'b1;
            end

            in_valid_q <= ((state_q == StSend) || (state_q == StFlush)) && !stop;
            in_data_q  <= ((state_q == StSend) && !stop) ? bus.mem_rd_data : FLUSH_PIX;

            if ((state_q == StIdle) && start) begin
                label_q       <= label;
                res_class_q   <= '0;
                res_hit_q     <= 1'b0;
                res_timeout_q <= 1'b0;
            end else if (accept) begin
                res_class_q   <= bus.cnn_class_out;
                res_hit_q     <= (bus.cnn_class_out == label_q);
                res_timeout_q <= 1'b0;
            end else if (expire) begin
                res_class_q   <= '0;
                res_hit_q     <= 1'b0;
                res_timeout_q <= 1'b1;
            end
        end
    end

    assign busy             = (state_q != StIdle) && (state_q != StDone);
    assign done             = (state_q == StDone);
    assign bus.cnn_rst_n    = cnn_rst_n_q;
    assign bus.cnn_in_valid = in_valid_q;
    assign bus.cnn_in_data  = in_data_q;
    assign res_class        = res_class_q;
    assign res_hit          = res_hit_q;
    assign res_timeout      = res_timeout_q;

`ifdef STATS_EN
    logic [15:0] frame_cnt_q, hit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            hit_cnt_q   <= '0;
        end else if (state_q == StDone) begin
            if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (res_hit_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign hit_cnt   = hit_cnt_q;
`else
    assign frame_cnt = '0;
    assign hit_cnt   = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Directed bench for cnn_frame_streamer: ramp image, hit/miss, timeout, abort and reset cases.
module tb_cnn_frame_streamer;
    import cnn_stream_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  label = 4'd0;
    logic        busy, done, res_hit, res_timeout;
    logic [3:0]  res_class;
    logic [15:0] frame_cnt, hit_cnt;

    int tests = 0;
    int fails = 0;

    cnn_frame_streamer_if #(.ADDR_W(10)) bus ();

    cnn_frame_streamer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .label       (label),
        .busy        (busy),
        .done        (done),
        .bus         (bus),
        .res_class   (res_class),
        .res_hit     (res_hit),
        .res_timeout (res_timeout),
        .frame_cnt   (frame_cnt),
        .hit_cnt     (hit_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous pixel RAM: data valid the cycle after the read strobe.
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
    end

    // Stream monitor, sampled on the falling edge.
    int   cyc      = 0;
    int   v_cnt    = 0;
    int   data_err = 0;
    int   first_v  = -1;
    int   last_v   = -1;
    int   first_rd = -1;
    int   rd_bad   = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    logic mon_clr  = 1'b0;
    logic [7:0] exp_pix;

    always @(negedge clk) begin
        if (mon_clr) begin
            v_cnt = 0; data_err = 0; first_v = -1; last_v = -1;
            first_rd = -1; rd_bad = 0; done_cnt = 0; done_cyc = -1;
        end else begin
            if (bus.cnn_in_valid) begin
                if (v_cnt == 0) first_v = cyc;
                last_v  = cyc;
                exp_pix = (v_cnt < 784) ? 8'(v_cnt) : 8'h00;
                if (bus.cnn_in_data !== exp_pix) data_err++;
                v_cnt++;
            end
            if (bus.mem_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                if (bus.mem_addr >= 10'd784) rd_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_frame(input logic [3:0] lbl, output int s);
        start = 1'b1;
        label = lbl;
        tick(1);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_v(input int target, input int max, output bit ok);
        int i = 0;
        while (v_cnt < target && i < max) begin
            tick(1);
            i++;
        end
        ok = (v_cnt >= target);
    endtask

    task automatic wait_done(input int max, output bit ok);
        int i = 0;
        while (done_cnt == 0 && i < max) begin
            tick(1);
            i++;
        end
        ok = (done_cnt != 0);
    endtask

    task automatic pulse_class(input logic [3:0] cls);
        bus.cnn_class_valid = 1'b1;
        bus.cnn_class_out   = cls;
        tick(1);
        bus.cnn_class_valid = 1'b0;
    endtask

`ifdef STATS_EN
    task automatic quick_frame(input logic [3:0] lbl, input logic [3:0] cls);
        int s;
        bit ok;
        clear_mon();
        start_frame(lbl, s);
        wait_v(20, 200, ok);
        check("q_stream", ok, 1);
        pulse_class(cls);
        wait_done(50, ok);
        check("q_done", ok, 1);
    endtask
`endif

    initial begin
        int s;
        bit ok;

        bus.cnn_class_valid = 1'b0;
        bus.cnn_class_out   = 4'd0;
        for (int k = 0; k < 1024; k++) ram[k] = 8'(k);

        // Reset state
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnn_rst_n", bus.cnn_rst_n, 0);
        check("rst_in_valid", bus.cnn_in_valid, 0);
        check("rst_rd_en", bus.mem_rd_en, 0);
        check("rst_res", {res_class, res_hit, res_timeout}, 0);
        rst_n = 1'b1;
        tick(2);

        // Frame 1: ramp image, class 7 = label 7, response 3 cycles after flush
        clear_mon();
        start_frame(4'd7, s);
        check("f1_busy", busy, 1);
        check("f1_crst_low", bus.cnn_rst_n, 0);
        wait_v(1204, 2000, ok);
        check("f1_stream_seen", ok, 1);
        tick(2);
        pulse_class(4'd7);
        check("f1_done", done, 1);
        check("f1_busy_drop", busy, 0);
        check("f1_in_valid_idle", bus.cnn_in_valid, 0);
        check("f1_first_valid_lat", first_v - s, 16);
        check("f1_first_read_lat", first_rd - s, 14);
        check("f1_valid_count", v_cnt, 1204);
        check("f1_contiguous", last_v - first_v + 1, 1204);
        check("f1_data_err", data_err, 0);
        check("f1_read_range", rd_bad, 0);
        tick(1);
        check("f1_done_pulse", done, 0);
        check("f1_done_count", done_cnt, 1);
        check("f1_res_class", res_class, 7);
        check("f1_res_hit", res_hit, 1);
        check("f1_res_timeout", res_timeout, 0);
        check("f1_cnn_rst_n_hold", bus.cnn_rst_n, 1);

        // Frame 2: label 5, class 3; class_valid in CRST and start while busy ignored
        clear_mon();
        start_frame(4'd5, s);
        check("f2_res_cleared", res_class, 0);
        tick(1);
        pulse_class(4'd3);
        check("f2_crst_class_ignored", busy, 1);
        tick(30);
        start = 1'b1;
        label = 4'd3;
        tick(3);
        start = 1'b0;
        wait_v(1204, 2000, ok);
        check("f2_stream_seen", ok, 1);
        pulse_class(4'd3);
        check("f2_done", done, 1);
        check("f2_first_valid_lat", first_v - s, 16);
        check("f2_valid_count", v_cnt, 1204);
        check("f2_data_err", data_err, 0);
        tick(1);
        check("f2_res_class", res_class, 3);
        check("f2_res_hit", res_hit, 0);
        check("f2_res_timeout", res_timeout, 0);
        check("f2_done_count", done_cnt, 1);

        // Frame 3: classifier never responds
        clear_mon();
        start_frame(4'd7, s);
        wait_done(6000, ok);
        check("f3_done_seen", ok, 1);
        check("f3_timeout_lat", done_cyc - first_v, 5000);
        check("f3_res_timeout", res_timeout, 1);
        check("f3_res_hit", res_hit, 0);
        check("f3_res_class", res_class, 0);
        check("f3_valid_count", v_cnt, 1204);

        // Frame 4: class_valid at flush cycle 100 aborts the stream
        clear_mon();
        start_frame(4'd2, s);
        wait_v(884, 2000, ok);
        check("f4_reach_flush", ok, 1);
        pulse_class(4'd2);
        check("f4_in_valid_drop", bus.cnn_in_valid, 0);
        check("f4_done", done, 1);
        check("f4_busy_drop", busy, 0);
        tick(1);
        check("f4_valid_count", v_cnt, 885);
        check("f4_res_class", res_class, 2);
        check("f4_res_hit", res_hit, 1);
        check("f4_res_timeout", res_timeout, 0);

`ifdef STATS_EN
        check("stat_frames_pre", frame_cnt, 4);
        check("stat_hits_pre", hit_cnt, 2);
`else
        check("stat_frames_off", frame_cnt, 0);
        check("stat_hits_off", hit_cnt, 0);
`endif

        // Frame 5: reset asserted mid-SEND
        clear_mon();
        start_frame(4'd1, s);
        wait_v(200, 500, ok);
        check("f5_reach_send", ok, 1);
        rst_n = 1'b0;
        #1;
        check("f5_busy", busy, 0);
        check("f5_done", done, 0);
        check("f5_in_valid", bus.cnn_in_valid, 0);
        check("f5_cnn_rst_n", bus.cnn_rst_n, 0);
        check("f5_rd_en", bus.mem_rd_en, 0);
        check("f5_addr", bus.mem_addr, 0);
        check("f5_stats", {frame_cnt, hit_cnt}, 0);
        tick(2);
        rst_n = 1'b1;
        clear_mon();
        tick(1400);
        check("f5_no_done", done_cnt, 0);
        check("f5_no_stream", v_cnt, 0);

`ifdef STATS_EN
        quick_frame(4'd1, 4'd1);
        quick_frame(4'd4, 4'd4);
        quick_frame(4'd6, 4'd9);
        quick_frame(4'd8, 4'd8);
        check("stat_frames", frame_cnt, 4);
        check("stat_hits", hit_cnt, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
